// File: rtl/cache_mem_arbiter_if.sv
// rtl/cache_mem_arbiter_if.sv - cache miss ports and memory line port seen by the arbiter
interface cache_mem_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 256
);
  logic                  i_read;
  logic [ADDR_WIDTH-1:0] i_addr;
  logic [LINE_WIDTH-1:0] i_rdata;
  logic                  i_resp;
  logic                  d_read;
  logic                  d_write;
  logic [ADDR_WIDTH-1:0] d_addr;
  logic [LINE_WIDTH-1:0] d_wdata;
  logic [LINE_WIDTH-1:0] d_rdata;
  logic                  d_resp;
  logic                  pmem_read;
  logic                  pmem_write;
  logic [ADDR_WIDTH-1:0] pmem_addr;
  logic [LINE_WIDTH-1:0] pmem_wdata;
  logic [LINE_WIDTH-1:0] pmem_rdata;
  logic                  pmem_resp;

  modport slave (
    input  i_read, i_addr, d_read, d_write, d_addr, d_wdata, pmem_rdata, pmem_resp,
    output i_rdata, i_resp, d_rdata, d_resp, pmem_read, pmem_write, pmem_addr, pmem_wdata
  );

  modport master (
    output i_read, i_addr, d_read, d_write, d_addr, d_wdata, pmem_rdata, pmem_resp,
    input  i_rdata, i_resp, d_rdata, d_resp, pmem_read, pmem_write, pmem_addr, pmem_wdata
  );
endinterface

// File: rtl/cache_mem_arbiter.sv
// rtl/cache_mem_arbiter.sv - round-robin arbiter sharing one memory line port between icache and dcache
module cache_mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 256
) (
  input logic              clk,
  input logic              rst,
  cache_mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, I_BUSY, D_BUSY, RESP} state_t;

  state_t                state;
  logic                  last_d;
  logic                  rd_q;
  logic                  wr_q;
  logic                  i_resp_q;
  logic                  d_resp_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LINE_WIDTH-1:0] wdata_q;
  logic [LINE_WIDTH-1:0] i_rdata_q;
  logic [LINE_WIDTH-1:0] d_rdata_q;
  logic                  d_req;
  logic                  pick_d;

  assign d_req  = bus.d_read | bus.d_write;
  // On a tie the side that did not win last time is served.
  assign pick_d = d_req & (~bus.i_read | ~last_d);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      last_d    <= 1'b0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      i_resp_q  <= 1'b0;
      d_resp_q  <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.i_read || d_req) begin
            last_d <= pick_d;
            if (pick_d) begin
              addr_q  <= bus.d_addr;
              wdata_q <= bus.d_wdata;
              wr_q    <= bus.d_write;
              rd_q    <= ~bus.d_write;
              state   <= D_BUSY;
            end else begin
              addr_q  <= bus.i_addr;
              wdata_q <= '0;
              wr_q    <= 1'b0;
              rd_q    <= 1'b1;
              state   <= I_BUSY;
            end
          end
        end
        I_BUSY, D_BUSY: begin
          if (bus.pmem_resp) begin
            rd_q  <= 1'b0;
            wr_q  <= 1'b0;
            state <= RESP;
            if (state == I_BUSY) begin
              i_rdata_q <= bus.pmem_rdata;
              i_resp_q  <= 1'b1;
            end else begin
              d_resp_q <= 1'b1;
              if (!wr_q) d_rdata_q <= bus.pmem_rdata;
            end
          end
        end
        RESP: begin
          i_resp_q <= 1'b0;
          d_resp_q <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.pmem_read  = rd_q;
  assign bus.pmem_write = wr_q;
  assign bus.pmem_addr  = addr_q;
  assign bus.pmem_wdata = wdata_q;
  assign bus.i_rdata    = i_rdata_q;
  assign bus.i_resp     = i_resp_q;
  assign bus.d_rdata    = d_rdata_q;
  assign bus.d_resp     = d_resp_q;
endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb/tb_cache_mem_arbiter.sv - self-checking bench for cache_mem_arbiter with transaction-level model
module tb_cache_mem_arbiter;
  localparam int AW = 32;
  localparam int LW = 256;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  cache_mem_arbiter_if #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) bus ();
  cache_mem_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    bit          ok;
    bit          rd;
    bit          wr;
    logic [AW-1:0] addr;
    logic [LW-1:0] wdata;
    int          waits;
    bit          stable;
    bit          got_i;
    bit          got_d;
    bit          busy_after;
    logic [LW-1:0] rdata;
    logic [LW-1:0] ird;
    logic [LW-1:0] drd;
  } txn_t;

  logic [LW-1:0] pm [logic [AW-1:0]];
  logic [LW-1:0] dflt_line;

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] v;
    for (int i = 0; i < LW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    bus.i_read = 0; bus.i_addr = '0; bus.d_read = 0; bus.d_write = 0;
    bus.d_addr = '0; bus.d_wdata = '0; bus.pmem_rdata = '0; bus.pmem_resp = 0;
  endtask

  task automatic do_reset();
    rst = 0; clear_inputs(); step(); step(); rst = 1; step();
  endtask

  // Acts as the memory: waits for a request, answers after lat cycles, reports what happened.
  task automatic serve_one(input int lat, input bit scr_i, input bit scr_d, output txn_t t);
    t.ok = 0; t.rd = 0; t.wr = 0; t.addr = '0; t.wdata = '0; t.waits = 0; t.stable = 1;
    t.got_i = 0; t.got_d = 0; t.busy_after = 0; t.rdata = '0; t.ird = '0; t.drd = '0;
    while (!(bus.pmem_read || bus.pmem_write) && t.waits < 40) begin
      step(); t.waits++;
    end
    if (!(bus.pmem_read || bus.pmem_write)) return;
    t.rd = bus.pmem_read; t.wr = bus.pmem_write; t.addr = bus.pmem_addr; t.wdata = bus.pmem_wdata;
    for (int c = 0; c < lat; c++) begin
      if (scr_i) bus.i_addr = $urandom;
      if (scr_d) begin bus.d_addr = $urandom; bus.d_wdata = rand_line(); end
      step();
      if (bus.pmem_addr !== t.addr || bus.pmem_wdata !== t.wdata ||
          bus.pmem_read !== t.rd || bus.pmem_write !== t.wr) t.stable = 0;
    end
    if (t.wr) begin
      pm[t.addr] = t.wdata;
      t.rdata = rand_line();
    end else begin
      t.rdata = pm.exists(t.addr) ? pm[t.addr] : dflt_line;
    end
    bus.pmem_rdata = t.rdata; bus.pmem_resp = 1;
    step();
    bus.pmem_resp = 0; bus.pmem_rdata = rand_line();
    t.got_i = bus.i_resp; t.got_d = bus.d_resp; t.ird = bus.i_rdata; t.drd = bus.d_rdata;
    t.busy_after = bus.pmem_read | bus.pmem_write;
    t.ok = 1;
  endtask

  task automatic test_reset();
    rst = 0; clear_inputs(); step(); step();
    checks++;
    if ({bus.pmem_read, bus.pmem_write, bus.i_resp, bus.d_resp} !== 4'b0) begin
      failures++; $display("FAIL reset_ctrl got=%b exp=0000", {bus.pmem_read, bus.pmem_write, bus.i_resp, bus.d_resp});
    end
    checks++;
    if (bus.pmem_addr !== '0) begin failures++; $display("FAIL reset_addr got=%h exp=0", bus.pmem_addr); end
    checks++;
    if (bus.pmem_wdata !== '0) begin failures++; $display("FAIL reset_wdata got=%h exp=0", bus.pmem_wdata); end
    checks++;
    if (bus.i_rdata !== '0 || bus.d_rdata !== '0) begin
      failures++; $display("FAIL reset_rdata got_i=%h got_d=%h exp=0", bus.i_rdata, bus.d_rdata);
    end
    rst = 1; step();
  endtask

  task automatic test_single_iread();
    logic [LW-1:0] a5;
    int ipulses = 0;
    bit dseen = 0;
    a5 = {(LW/8){8'hA5}};
    bus.i_addr = 32'h0000_1000; bus.i_read = 1;
    step();
    checks++;
    if (bus.pmem_read !== 1 || bus.pmem_write !== 0 || bus.pmem_addr !== 32'h1000) begin
      failures++; $display("FAIL iread_start got rd=%b wr=%b addr=%h exp rd=1 wr=0 addr=00001000", bus.pmem_read, bus.pmem_write, bus.pmem_addr);
    end
    for (int c = 0; c < 2; c++) begin
      step(); ipulses += int'(bus.i_resp); dseen |= bus.d_resp;
    end
    checks++;
    if (bus.pmem_read !== 1 || bus.pmem_addr !== 32'h1000) begin
      failures++; $display("FAIL iread_hold got rd=%b addr=%h exp rd=1 addr=00001000", bus.pmem_read, bus.pmem_addr);
    end
    bus.pmem_rdata = a5; bus.pmem_resp = 1;
    step();
    bus.pmem_resp = 0; bus.pmem_rdata = '0; bus.i_read = 0;
    ipulses += int'(bus.i_resp); dseen |= bus.d_resp;
    checks++;
    if (bus.i_resp !== 1 || bus.i_rdata !== a5 || bus.pmem_read !== 0) begin
      failures++; $display("FAIL iread_resp got resp=%b rd=%b rdata=%h exp resp=1 rd=0 rdata=%h", bus.i_resp, bus.pmem_read, bus.i_rdata, a5);
    end
    for (int c = 0; c < 4; c++) begin
      step(); ipulses += int'(bus.i_resp); dseen |= bus.d_resp;
    end
    checks++;
    if (ipulses != 1 || dseen) begin
      failures++; $display("FAIL iread_pulses got i=%0d d=%b exp i=1 d=0", ipulses, dseen);
    end
    checks++;
    if (bus.i_rdata !== a5 || bus.pmem_read !== 0) begin
      failures++; $display("FAIL iread_after got rdata=%h rd=%b exp rdata=%h rd=0", bus.i_rdata, bus.pmem_read, a5);
    end
  endtask

  task automatic test_tie_alternation();
    logic [LW-1:0] dw;
    txn_t t;
    dw = {(LW/32){32'h1234_5678}};
    do_reset();
    for (int r = 0; r < 2; r++) begin
      bus.i_read = 1; bus.i_addr = 32'h2000;
      bus.d_write = 1; bus.d_addr = 32'h3000; bus.d_wdata = dw;
      serve_one(2, 0, 0, t);
      checks++;
      if (!t.ok || !t.wr || t.rd || t.addr !== 32'h3000 || t.wdata !== dw || !t.got_d || t.got_i || t.waits != 1) begin
        failures++; $display("FAIL tie_d_first r=%0d got ok=%b wr=%b rd=%b addr=%h waits=%0d d=%b i=%b exp D write 00003000 waits=1", r, t.ok, t.wr, t.rd, t.addr, t.waits, t.got_d, t.got_i);
      end
      bus.d_write = 0;
      step();
      checks++;
      if (bus.pmem_read !== 0 || bus.pmem_write !== 0 || bus.d_resp !== 0) begin
        failures++; $display("FAIL tie_gap r=%0d got rd=%b wr=%b dresp=%b exp 0", r, bus.pmem_read, bus.pmem_write, bus.d_resp);
      end
      serve_one(1, 0, 0, t);
      checks++;
      if (!t.ok || !t.rd || t.wr || t.addr !== 32'h2000 || !t.got_i || t.got_d || t.ird !== dflt_line || t.waits != 1) begin
        failures++; $display("FAIL tie_i_second r=%0d got ok=%b rd=%b addr=%h waits=%0d i=%b rdata=%h exp I read 00002000 waits=1", r, t.ok, t.rd, t.addr, t.waits, t.got_i, t.ird);
      end
      bus.i_read = 0;
      step();
    end
  endtask

  task automatic test_rw_both();
    logic [LW-1:0] wd;
    txn_t t;
    bus.d_read = 1; bus.d_addr = 32'h6100;
    serve_one(1, 0, 0, t);
    bus.d_read = 0; step();
    checks++;
    if (!t.ok || !t.rd || !t.got_d || t.drd !== dflt_line) begin
      failures++; $display("FAIL rw_prime got ok=%b rd=%b d=%b rdata=%h exp rdata=%h", t.ok, t.rd, t.got_d, t.drd, dflt_line);
    end
    wd = rand_line();
    bus.d_read = 1; bus.d_write = 1; bus.d_addr = 32'h6000; bus.d_wdata = wd;
    serve_one(3, 0, 0, t);
    bus.d_read = 0; bus.d_write = 0;
    checks++;
    if (!t.ok || !t.wr || t.rd || t.addr !== 32'h6000 || t.wdata !== wd || !t.stable) begin
      failures++; $display("FAIL rw_write_only got ok=%b wr=%b rd=%b addr=%h stable=%b exp wr=1 rd=0 addr=00006000", t.ok, t.wr, t.rd, t.addr, t.stable);
    end
    checks++;
    if (!t.got_d || t.got_i || t.drd !== dflt_line) begin
      failures++; $display("FAIL rw_rdata_kept got d=%b i=%b rdata=%h exp d=1 rdata=%h", t.got_d, t.got_i, t.drd, dflt_line);
    end
    step();
  endtask

  task automatic test_busy_isolation();
    logic [LW-1:0] line;
    txn_t t;
    line = rand_line();
    bus.i_read = 1; bus.i_addr = 32'h4000;
    step();
    bus.i_addr = 32'hDEAD_0000; bus.d_read = 1; bus.d_addr = 32'h5000;
    step(); step();
    checks++;
    if (bus.pmem_read !== 1 || bus.pmem_write !== 0 || bus.pmem_addr !== 32'h4000) begin
      failures++; $display("FAIL busy_latched got rd=%b wr=%b addr=%h exp rd=1 wr=0 addr=00004000", bus.pmem_read, bus.pmem_write, bus.pmem_addr);
    end
    bus.pmem_rdata = line; bus.pmem_resp = 1;
    step();
    bus.pmem_resp = 0; bus.i_read = 0;
    checks++;
    if (bus.i_resp !== 1 || bus.d_resp !== 0 || bus.i_rdata !== line || bus.pmem_read !== 0) begin
      failures++; $display("FAIL busy_iresp got i=%b d=%b rd=%b rdata=%h exp i=1 d=0 rd=0 rdata=%h", bus.i_resp, bus.d_resp, bus.pmem_read, bus.i_rdata, line);
    end
    step();
    checks++;
    if (bus.pmem_read !== 0 || bus.pmem_write !== 0 || bus.i_resp !== 0) begin
      failures++; $display("FAIL busy_idle_gap got rd=%b wr=%b iresp=%b exp 0", bus.pmem_read, bus.pmem_write, bus.i_resp);
    end
    step();
    checks++;
    if (bus.pmem_read !== 1 || bus.pmem_addr !== 32'h5000) begin
      failures++; $display("FAIL busy_d_next got rd=%b addr=%h exp rd=1 addr=00005000", bus.pmem_read, bus.pmem_addr);
    end
    serve_one(0, 0, 0, t);
    bus.d_read = 0;
    checks++;
    if (!t.ok || !t.got_d || t.got_i || t.drd !== dflt_line || t.busy_after) begin
      failures++; $display("FAIL busy_d_resp got ok=%b d=%b i=%b rdata=%h exp d=1 rdata=%h", t.ok, t.got_d, t.got_i, t.drd, dflt_line);
    end
    step();
  endtask

  task automatic test_spurious_and_reset();
    txn_t t;
    clear_inputs(); step();
    bus.pmem_resp = 1; bus.pmem_rdata = rand_line();
    step();
    bus.pmem_resp = 0;
    checks++;
    if ({bus.i_resp, bus.d_resp, bus.pmem_read, bus.pmem_write} !== 4'b0) begin
      failures++; $display("FAIL spurious_resp got=%b exp=0000", {bus.i_resp, bus.d_resp, bus.pmem_read, bus.pmem_write});
    end
    bus.d_read = 1; bus.d_addr = 32'h7000;
    serve_one(1, 0, 0, t);
    bus.d_read = 0;
    checks++;
    if (!t.ok || !t.rd || t.addr !== 32'h7000 || t.waits != 1 || !t.got_d) begin
      failures++; $display("FAIL spurious_then_read got ok=%b rd=%b addr=%h waits=%0d d=%b exp rd=1 addr=00007000 waits=1", t.ok, t.rd, t.addr, t.waits, t.got_d);
    end
    step();
    bus.d_read = 1; bus.d_addr = 32'h7100;
    step();
    rst = 0;
    #1;
    checks++;
    if ({bus.pmem_read, bus.pmem_write, bus.i_resp, bus.d_resp} !== 4'b0 || bus.pmem_addr !== '0 ||
        bus.pmem_wdata !== '0 || bus.d_rdata !== '0 || bus.i_rdata !== '0) begin
      failures++; $display("FAIL midreset_outputs got rd=%b wr=%b addr=%h drdata=%h exp all 0", bus.pmem_read, bus.pmem_write, bus.pmem_addr, bus.d_rdata);
    end
    bus.d_read = 0;
    step(); rst = 1; step();
    checks++;
    if (bus.pmem_read !== 0 || bus.pmem_write !== 0 || bus.d_resp !== 0) begin
      failures++; $display("FAIL midreset_idle got rd=%b wr=%b dresp=%b exp 0", bus.pmem_read, bus.pmem_write, bus.d_resp);
    end
    bus.d_read = 1; bus.d_addr = 32'h7200;
    serve_one(2, 0, 0, t);
    bus.d_read = 0;
    checks++;
    if (!t.ok || !t.rd || t.addr !== 32'h7200 || t.waits != 1 || !t.got_d || t.drd !== dflt_line) begin
      failures++; $display("FAIL midreset_fresh got ok=%b rd=%b addr=%h waits=%0d d=%b rdata=%h exp rd=1 addr=00007200 rdata=%h", t.ok, t.rd, t.addr, t.waits, t.got_d, t.drd, dflt_line);
    end
    step();
  endtask

  task automatic test_random();
    logic [LW-1:0] model_mem [8];
    logic [LW-1:0] exp_i, exp_d, dw;
    logic [AW-1:0] ia, da;
    bit last_d, ri, rdr, rdw, dreq, first_d, owner_d, exp_wr;
    int ii, di, n;
    txn_t t;
    do_reset();
    exp_i = '0; exp_d = '0; last_d = 0;
    for (int k = 0; k < 8; k++) begin
      model_mem[k] = rand_line();
      pm[32'h0001_0000 + k * 32] = model_mem[k];
    end
    for (int r = 0; r < 60; r++) begin
      ri = 1'($urandom); rdr = 1'($urandom); rdw = 1'($urandom);
      if (!ri && !rdr && !rdw) ri = 1;
      ii = int'($urandom_range(7)); di = int'($urandom_range(7));
      ia = 32'h0001_0000 + ii * 32; da = 32'h0001_0000 + di * 32;
      dw = rand_line();
      bus.i_read = ri; bus.i_addr = ia; bus.d_read = rdr; bus.d_write = rdw; bus.d_addr = da; bus.d_wdata = dw;
      dreq = rdr | rdw;
      n = int'(ri) + int'(dreq);
      first_d = dreq && (!ri || !last_d);
      for (int k = 0; k < n; k++) begin
        owner_d = (k == 0) ? first_d : !first_d;
        exp_wr = owner_d && rdw;
        serve_one(int'($urandom_range(3)), !owner_d, owner_d, t);
        checks++;
        if (!t.ok) begin
          failures++; $display("FAIL rand_timeout r=%0d k=%0d", r, k);
          clear_inputs(); do_reset(); return;
        end
        checks++;
        if (t.wr !== exp_wr || t.rd !== !exp_wr || t.addr !== (owner_d ? da : ia) || !t.stable) begin
          failures++; $display("FAIL rand_grant r=%0d got wr=%b rd=%b addr=%h stable=%b exp wr=%b addr=%h", r, t.wr, t.rd, t.addr, t.stable, exp_wr, owner_d ? da : ia);
        end
        if (exp_wr) begin
          checks++;
          if (t.wdata !== dw) begin failures++; $display("FAIL rand_wdata r=%0d got=%h exp=%h", r, t.wdata, dw); end
          model_mem[di] = dw;
        end else if (owner_d) begin
          exp_d = model_mem[di];
        end else begin
          exp_i = model_mem[ii];
        end
        checks++;
        if (t.got_i !== !owner_d || t.got_d !== owner_d || t.busy_after) begin
          failures++; $display("FAIL rand_resp r=%0d got i=%b d=%b busy=%b exp i=%b d=%b busy=0", r, t.got_i, t.got_d, t.busy_after, !owner_d, owner_d);
        end
        checks++;
        if (t.ird !== exp_i || t.drd !== exp_d) begin
          failures++; $display("FAIL rand_rdata r=%0d got i=%h d=%h exp i=%h d=%h", r, t.ird, t.drd, exp_i, exp_d);
        end
        last_d = owner_d;
        if (owner_d) begin bus.d_read = 0; bus.d_write = 0; end
        else bus.i_read = 0;
        step();
        checks++;
        if ({bus.pmem_read, bus.pmem_write, bus.i_resp, bus.d_resp} !== 4'b0) begin
          failures++; $display("FAIL rand_idle r=%0d got=%b exp=0000", r, {bus.pmem_read, bus.pmem_write, bus.i_resp, bus.d_resp});
        end
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 0;
    clear_inputs();
    dflt_line = rand_line();
    test_reset();
    test_single_iread();
    test_tie_alternation();
    test_rw_both();
    test_busy_isolation();
    test_spurious_and_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cache_mem_arbiter.md
Name: cache_mem_arbiter

Overview:
- Shares the single physical-memory line port between the instruction-cache miss path (feeding fetch) and the data-cache miss/writeback path.
- Sits between both caches and the cacheline adaptor.
- Serialises line transactions with a small FSM and round-robin tie-break.
- Latches address/data at grant so requester-side changes cannot corrupt an in-flight burst.

Parameters:
ADDR_WIDTH, 32, physical byte address width
LINE_WIDTH, 256, cache line width in bits

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset (asserted when 0)
i_read  input  1  icache line read request, held until i_resp
i_addr  input  ADDR_WIDTH  icache line address
i_rdata  output  LINE_WIDTH  line returned to icache
i_resp  output  1  one-cycle completion pulse to icache
d_read  input  1  dcache line read request, held until d_resp
d_write  input  1  dcache line writeback request, held until d_resp
d_addr  input  ADDR_WIDTH  dcache line address
d_wdata  input  LINE_WIDTH  dcache writeback line
d_rdata  output  LINE_WIDTH  line returned to dcache
d_resp  output  1  one-cycle completion pulse to dcache
pmem_read  output  1  memory read request
pmem_write  output  1  memory write request
pmem_addr  output  ADDR_WIDTH  memory address
pmem_wdata  output  LINE_WIDTH  memory write line
pmem_rdata  input  LINE_WIDTH  memory read line
pmem_resp  input  1  memory completion, valid one cycle

Behaviour:
- Reset (rst=0, async):
  - state=IDLE, last_grant=I.
  - All outputs 0; latched addr/wdata 0.
- States:
  - IDLE: sample requests.
    - d_req = d_read|d_write.
    - Only i_read -> I_BUSY. Only d_req -> D_BUSY.
    - Both -> grant the requester not equal to last_grant; after reset D wins the first tie.
    - On grant: latch addr, wdata and op (d_write has priority over d_read if both high); update last_grant.
  - I_BUSY / D_BUSY:
    - pmem_read / pmem_write driven from the latched op; pmem_addr and pmem_wdata from latches.
    - Request inputs ignored.
    - On pmem_resp=1: capture pmem_rdata into the owner's rdata register (reads only), drop pmem_read/pmem_write, go to RESP.
  - RESP:
    - Owner's resp=1 for exactly this cycle; rdata valid and held until next capture.
    - Unconditionally -> IDLE.
- Latency:
  - Request seen in IDLE at cycle 0 -> pmem_* asserted at cycle 1.
  - pmem_resp at cycle k -> *_resp at cycle k+1, IDLE at k+2.
  - Minimum turnaround between back-to-back grants is 1 IDLE cycle.
- pmem_read and pmem_write are never both 1.
- pmem_* never asserted in IDLE or RESP.
- pmem_resp in IDLE or RESP is ignored, with no state change.
- Requester addr/wdata changes during BUSY have no effect on pmem outputs.
- Requesters must deassert by the cycle after resp.
  - A request still high in IDLE is treated as new.
- Writes:
  - A write completion still pulses d_resp.
  - d_rdata is left unchanged.
- Reset mid-transaction:
  - Immediate return to IDLE with all outputs 0.
  - The in-flight request is dropped; the requester re-requests.

Test Plan:
- i_read=1, i_addr=0x0000_1000, pmem_resp after 3 cycles with rdata=0xA5..A5 -> pmem_read=1 from cycle 1 with addr 0x1000; i_resp pulses once, 1 cycle after pmem_resp, with i_rdata=0xA5..A5; d_resp never 1.
- Simultaneous i_read (0x2000) and d_write (0x3000, wdata=0x1234..) right after reset -> D granted first (pmem_write=1, addr 0x3000); I then served at 0x2000; grants alternate on repeated ties (D,I,D,I).
- d_read and d_write both 1 -> only pmem_write asserted; d_rdata unchanged after d_resp.
- During I_BUSY change i_addr to 0xDEAD_0000 and raise d_read -> pmem_addr stays at the latched value; D is served only after the I RESP+IDLE sequence.
- Spurious pmem_resp in IDLE -> no resp pulse, no state change; rst=0 mid-D_BUSY -> all outputs 0 in the same cycle, FSM in IDLE on release, a fresh d_read is served normally.
